// File: rtl/axi_fft_master_pkg.sv
// Shared types and constants for the FFT sample-RAM AXI initiator.
// Holds the FSM state type, AXI encodings and the burst-legality helper.
package axi_fft_master_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_AW,
      ST_W,
      ST_B,
      ST_WAIT_CALC,
      ST_AR,
      ST_R,
      ST_DONE
   } master_fsm;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [2:0] SIZE_2B    = 3'b001;
   localparam logic [2:0] SIZE_4B    = 3'b010;
   localparam int         MAX_BURST  = 256;
   localparam int         ADDR_SPACE = 4096;

   // 13-bit sum so a burst running past the 4 KB window is visible.
   function automatic logic start_legal(input logic [11:0] base, input logic [8:0] num);
      logic [12:0] end_addr;
      end_addr = {1'b0, base} + {3'b000, num, 1'b0};
      return (num != 9'd0) && (num <= 9'(MAX_BURST)) && (end_addr <= 13'(ADDR_SPACE));
   endfunction

endpackage

// File: rtl/axi_fft_master_beat_cnt.sv
// Beat counter shared by the write-data and read-data phases.
// Cleared on the address handshake, advanced per data beat, flags the final beat.
module axi_fft_master_beat_cnt (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] last_idx,
   output logic       last
);

   logic [8:0] cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst)    cnt <= 9'd0;
      else if (clr) cnt <= 9'd0;
      else if (en)  cnt <= cnt + 9'd1;
   end

   assign last = (cnt == {1'b0, last_idx});

endmodule

// File: rtl/axi_fft_master.sv
// AXI4 initiator: writes one 16-bit sample burst, waits for the FFT, reads back results.
// Optional watchdog on stalled handshakes: define AXI_FFT_MASTER_TIMEOUT_EN.
//
// state      | meaning
// IDLE       | waiting for a legal i_START
// AW         | write address offered
// W          | sample stream passed through to W channel
// B          | waiting for write response
// WAIT_CALC  | waiting for FFT calculation end
// AR         | read address offered
// R          | R channel passed through to result sink
// DONE       | one-cycle completion pulse
module axi_fft_master
   import axi_fft_master_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ID_W_WIDTH     = 2,
   parameter int ID_R_WIDTH     = 2,
   parameter int WR_ID          = 0,
   parameter int RD_ID          = 0,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_START,
   input  logic [11:0]           i_BASE_ADDR,
   input  logic [8:0]            i_NUM_SAMPLES,
   input  logic                  i_CALC_END,
   input  logic [15:0]           i_SRC_DATA,
   input  logic                  i_SRC_VALID,
   output logic                  o_SRC_READY,
   output logic [DATA_WIDTH-1:0] o_RES_DATA,
   output logic                  o_RES_VALID,
   input  logic                  i_RES_READY,
   output logic                  o_BUSY,
   output logic                  o_DONE,
   output logic                  o_ERROR,
   output logic [11:0]           o_AWADDR,
   output logic [7:0]            o_AWLEN,
   output logic [2:0]            o_AWSIZE,
   output logic [1:0]            o_AWBURST,
   output logic [ID_W_WIDTH-1:0] o_AWID,
   output logic                  o_AWVALID,
   input  logic                  i_AWREADY,
   output logic [15:0]           o_WDATA,
   output logic [1:0]            o_WSTRB,
   output logic                  o_WVALID,
   output logic                  o_WLAST,
   input  logic                  i_WREADY,
   input  logic                  i_BVALID,
   input  logic [ID_W_WIDTH-1:0] i_BID,
   output logic                  o_BREADY,
   output logic [11:0]           o_ARADDR,
   output logic [7:0]            o_ARLEN,
   output logic [2:0]            o_ARSIZE,
   output logic [1:0]            o_ARBURST,
   output logic [ID_R_WIDTH-1:0] o_ARID,
   output logic                  o_ARVALID,
   input  logic                  i_ARREADY,
   input  logic [DATA_WIDTH-1:0] i_RDATA,
   input  logic [ID_R_WIDTH-1:0] i_RID,
   input  logic                  i_RVALID,
   input  logic                  i_RLAST,
   output logic                  o_RREADY
);

   master_fsm   state;
   logic [11:0] addr_q;
   logic [7:0]  len_q;
   logic        beat_last;
   logic        w_beat;
   logic        r_beat;
   logic        beat_clr;
   logic        wd_expire;

   assign w_beat   = (state == ST_W) && i_SRC_VALID && i_WREADY;
   assign r_beat   = (state == ST_R) && i_RVALID && i_RES_READY;
   assign beat_clr = (o_AWVALID && i_AWREADY) || (o_ARVALID && i_ARREADY);

   axi_fft_master_beat_cnt u_beat_cnt (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .clr      (beat_clr),
      .en       (w_beat || r_beat),
      .last_idx (len_q),
      .last     (beat_last)
   );

   assign o_AWADDR  = addr_q;
   assign o_AWLEN   = len_q;
   assign o_AWSIZE  = SIZE_2B;
   assign o_AWBURST = BURST_INCR;
   assign o_AWID    = ID_W_WIDTH'(WR_ID);
   assign o_ARADDR  = addr_q;
   assign o_ARLEN   = len_q;
   assign o_ARSIZE  = SIZE_4B;
   assign o_ARBURST = BURST_INCR;
   assign o_ARID    = ID_R_WIDTH'(RD_ID);

   // Data channels are zero-latency pass-throughs gated by phase.
   assign o_WDATA     = i_SRC_DATA;
   assign o_WSTRB     = 2'b11;
   assign o_WVALID    = (state == ST_W) && i_SRC_VALID;
   assign o_WLAST     = (state == ST_W) && beat_last;
   assign o_SRC_READY = (state == ST_W) && i_WREADY;
   assign o_RES_DATA  = i_RDATA;
   assign o_RES_VALID = (state == ST_R) && i_RVALID;
   assign o_RREADY    = (state == ST_R) && i_RES_READY;

`ifdef AXI_FFT_MASTER_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic [WD_W-1:0] wd_cnt;
   logic            wd_run;
   logic            wd_hs;

   always_comb begin
      wd_run = 1'b0;
      wd_hs  = 1'b0;
      case (state)
         ST_AW:   begin wd_run = 1'b1; wd_hs = i_AWREADY; end
         ST_W:    begin wd_run = 1'b1; wd_hs = w_beat;    end
         ST_B:    begin wd_run = 1'b1; wd_hs = i_BVALID;  end
         ST_AR:   begin wd_run = 1'b1; wd_hs = i_ARREADY; end
         ST_R:    begin wd_run = 1'b1; wd_hs = r_beat;    end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || !wd_run || wd_hs) wd_cnt <= '0;
      else                           wd_cnt <= wd_cnt + WD_W'(1);
   end

   assign wd_expire = wd_run && !wd_hs && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES != 0);
   assign wd_expire      = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= ST_IDLE;
         addr_q    <= 12'd0;
         len_q     <= 8'd0;
         o_AWVALID <= 1'b0;
         o_BREADY  <= 1'b0;
         o_ARVALID <= 1'b0;
         o_BUSY    <= 1'b0;
         o_DONE    <= 1'b0;
         o_ERROR   <= 1'b0;
      end else begin
         o_DONE  <= 1'b0;
         o_ERROR <= 1'b0;
         if (wd_expire) begin
            state     <= ST_IDLE;
            o_AWVALID <= 1'b0;
            o_BREADY  <= 1'b0;
            o_ARVALID <= 1'b0;
            o_BUSY    <= 1'b0;
            o_ERROR   <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (i_START) begin
                     if (start_legal(i_BASE_ADDR, i_NUM_SAMPLES)) begin
                        addr_q    <= i_BASE_ADDR;
                        len_q     <= 8'(i_NUM_SAMPLES - 9'd1);
                        o_AWVALID <= 1'b1;
                        o_BUSY    <= 1'b1;
                        state     <= ST_AW;
                     end else begin
                        o_ERROR <= 1'b1;
                     end
                  end
               end
               ST_AW: begin
                  if (i_AWREADY) begin
                     o_AWVALID <= 1'b0;
                     state     <= ST_W;
                  end
               end
               ST_W: begin
                  if (w_beat && beat_last) begin
                     o_BREADY <= 1'b1;
                     state    <= ST_B;
                  end
               end
               ST_B: begin
                  if (i_BVALID) begin
                     o_BREADY <= 1'b0;
                     if (i_BID != ID_W_WIDTH'(WR_ID)) begin
                        o_ERROR <= 1'b1;
                        o_BUSY  <= 1'b0;
                        state   <= ST_IDLE;
                     end else begin
                        state <= ST_WAIT_CALC;
                     end
                  end
               end
               ST_WAIT_CALC: begin
                  if (i_CALC_END) begin
                     o_ARVALID <= 1'b1;
                     state     <= ST_AR;
                  end
               end
               ST_AR: begin
                  if (i_ARREADY) begin
                     o_ARVALID <= 1'b0;
                     state     <= ST_R;
                  end
               end
               ST_R: begin
                  // RLAST must coincide exactly with the counted final beat.
                  if (r_beat) begin
                     if ((i_RID != ID_R_WIDTH'(RD_ID)) || (i_RLAST != beat_last)) begin
                        o_ERROR <= 1'b1;
                        o_BUSY  <= 1'b0;
                        state   <= ST_IDLE;
                     end else if (beat_last) begin
                        o_DONE <= 1'b1;
                        state  <= ST_DONE;
                     end
                  end
               end
               ST_DONE: begin
                  o_BUSY <= 1'b0;
                  state  <= ST_IDLE;
               end
               default: begin
                  o_BUSY <= 1'b0;
                  state  <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_axi_fft_master.sv
// Self-checking bench for axi_fft_master: randomized jobs driven through a bench-side
// AXI slave / stream model and checked against expected bursts computed from the job.
module tb_axi_fft_master;

   logic        i_clk = 1'b0;
   logic        i_rst, i_START, i_CALC_END, i_SRC_VALID, i_RES_READY;
   logic [11:0] i_BASE_ADDR;
   logic [8:0]  i_NUM_SAMPLES;
   logic [15:0] i_SRC_DATA;
   logic        i_AWREADY, i_WREADY, i_BVALID, i_ARREADY, i_RVALID, i_RLAST;
   logic [1:0]  i_BID, i_RID;
   logic [31:0] i_RDATA;
   logic        o_SRC_READY, o_RES_VALID, o_BUSY, o_DONE, o_ERROR;
   logic [31:0] o_RES_DATA;
   logic [11:0] o_AWADDR, o_ARADDR;
   logic [7:0]  o_AWLEN, o_ARLEN;
   logic [2:0]  o_AWSIZE, o_ARSIZE;
   logic [1:0]  o_AWBURST, o_ARBURST, o_AWID, o_ARID, o_WSTRB;
   logic        o_AWVALID, o_WVALID, o_WLAST, o_BREADY, o_ARVALID, o_RREADY;
   logic [15:0] o_WDATA;

   always #5 i_clk = ~i_clk;

   axi_fft_master #(
      .DATA_WIDTH(32), .ID_W_WIDTH(2), .ID_R_WIDTH(2),
      .WR_ID(0), .RD_ID(0), .TIMEOUT_CYCLES(16)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_START(i_START), .i_BASE_ADDR(i_BASE_ADDR),
      .i_NUM_SAMPLES(i_NUM_SAMPLES), .i_CALC_END(i_CALC_END),
      .i_SRC_DATA(i_SRC_DATA), .i_SRC_VALID(i_SRC_VALID), .o_SRC_READY(o_SRC_READY),
      .o_RES_DATA(o_RES_DATA), .o_RES_VALID(o_RES_VALID), .i_RES_READY(i_RES_READY),
      .o_BUSY(o_BUSY), .o_DONE(o_DONE), .o_ERROR(o_ERROR),
      .o_AWADDR(o_AWADDR), .o_AWLEN(o_AWLEN), .o_AWSIZE(o_AWSIZE), .o_AWBURST(o_AWBURST),
      .o_AWID(o_AWID), .o_AWVALID(o_AWVALID), .i_AWREADY(i_AWREADY),
      .o_WDATA(o_WDATA), .o_WSTRB(o_WSTRB), .o_WVALID(o_WVALID), .o_WLAST(o_WLAST),
      .i_WREADY(i_WREADY), .i_BVALID(i_BVALID), .i_BID(i_BID), .o_BREADY(o_BREADY),
      .o_ARADDR(o_ARADDR), .o_ARLEN(o_ARLEN), .o_ARSIZE(o_ARSIZE), .o_ARBURST(o_ARBURST),
      .o_ARID(o_ARID), .o_ARVALID(o_ARVALID), .i_ARREADY(i_ARREADY),
      .i_RDATA(i_RDATA), .i_RID(i_RID), .i_RVALID(i_RVALID), .i_RLAST(i_RLAST),
      .o_RREADY(o_RREADY)
   );

   int vectors = 0;
   int miscompares = 0;

   // Observations gathered by run_job
   int          aw_cnt, ar_cnt, b_cnt, done_cnt, err_cnt, aw_first, err_first;
   int          aw_unstable, stall_bad, strb_bad, src_mis, ar_early;
   logic        timed_out, post_rst_bad, aw_at_err;
   logic [11:0] aw_addr, ar_addr;
   logic [7:0]  aw_len, ar_len;
   logic [2:0]  aw_size, ar_size;
   logic [1:0]  aw_burst, ar_burst, aw_id, ar_id;
   logic [15:0] w_q[$];
   logic        wl_q[$];
   logic [31:0] res_q[$];
   // Reference job content
   logic [15:0] src_q[$];
   logic [31:0] rd_q[$];

   function automatic bit model_legal(int base, int n);
      return (n >= 1) && (n <= 256) && (base + 2 * n <= 4096);
   endfunction

   task automatic idle_inputs();
      i_START = 0; i_CALC_END = 0; i_SRC_VALID = 0; i_SRC_DATA = 0; i_RES_READY = 0;
      i_AWREADY = 0; i_WREADY = 0; i_BVALID = 0; i_BID = 0; i_ARREADY = 0;
      i_RVALID = 0; i_RLAST = 0; i_RID = 0; i_RDATA = 0;
   endtask

   task automatic apply_reset();
      @(negedge i_clk);
      idle_inputs();
      i_rst = 1;
      repeat (2) @(negedge i_clk);
      i_rst = 0;
   endtask

   task automatic prep_data(int n, bit fixed);
      src_q.delete(); rd_q.delete();
      for (int i = 0; i < n && i < 256; i++) begin
         src_q.push_back(fixed ? 16'((i + 1) * 16'h1111) : 16'($urandom));
         rd_q.push_back($urandom);
      end
   endtask

   // Bench-side source, AXI slave and sink for one start command.
   task automatic run_job(int base, int n, int aw_dly, int ar_dly, int p_w, int p_s,
                          int p_r, int p_rv, int bid, int rlast_beat, int calc_dly,
                          int rst_beat, int max_cyc);
      int src_idx = 0, rd_idx = 0, aw_wait = 0, ar_wait = 0, calc_wait = -1, c;
      bit b_pend = 0, r_act = 0, s_hold = 0, rv_hold = 0, calc_seen = 0;
      bit p_aw_st = 0, p_ar_st = 0, p_w_st = 0, p_wlast = 0;
      logic [11:0] p_awaddr = 0, p_araddr = 0;
      logic [7:0]  p_awlen = 0, p_arlen = 0;
      logic [15:0] p_wdata = 0;
      aw_cnt = 0; ar_cnt = 0; b_cnt = 0; done_cnt = 0; err_cnt = 0; aw_first = -1;
      err_first = -1; aw_unstable = 0; stall_bad = 0; strb_bad = 0; src_mis = 0;
      ar_early = 0; timed_out = 0; post_rst_bad = 0; aw_at_err = 0;
      w_q.delete(); wl_q.delete(); res_q.delete();
      for (c = 0; c < max_cyc; c++) begin
         @(negedge i_clk);
         i_START       = (c == 0);
         i_BASE_ADDR   = 12'(base);
         i_NUM_SAMPLES = 9'(n);
         i_SRC_VALID   = (src_idx < src_q.size()) && (s_hold || $urandom_range(99) < p_s);
         i_SRC_DATA    = i_SRC_VALID ? src_q[src_idx] : 16'($urandom);
         i_WREADY      = $urandom_range(99) < p_w;
         i_AWREADY     = aw_wait >= aw_dly;
         i_ARREADY     = ar_wait >= ar_dly;
         i_BVALID      = b_pend;
         i_BID         = 2'(bid);
         i_CALC_END    = (calc_wait >= calc_dly);
         i_RVALID      = r_act && (rd_idx < rd_q.size()) && (rv_hold || $urandom_range(99) < p_rv);
         i_RDATA       = i_RVALID ? rd_q[rd_idx] : $urandom;
         i_RID         = 2'd0;
         i_RLAST       = i_RVALID && ((rlast_beat >= 0) ? (rd_idx == rlast_beat) : (rd_idx == n - 1));
         i_RES_READY   = $urandom_range(99) < p_r;
         i_rst         = (rst_beat >= 0) && (aw_cnt == 1) && (w_q.size() == rst_beat);
         #1;
         if (i_rst) begin
            @(posedge i_clk); #1;
            post_rst_bad = o_AWVALID | o_WVALID | o_ARVALID | o_RES_VALID | o_BREADY |
                           o_RREADY | o_SRC_READY | o_BUSY | o_DONE | o_ERROR;
            i_rst = 0;
            break;
         end
         if (o_ARVALID && !calc_seen) ar_early++;
         if (i_CALC_END) calc_seen = 1;
         if (o_ERROR) begin
            err_cnt++;
            if (err_first < 0) begin err_first = c; aw_at_err = o_AWVALID; end
         end
         if (o_DONE) done_cnt++;
         if (o_AWVALID && aw_first < 0) aw_first = c;
         if (p_aw_st && (!o_AWVALID || o_AWADDR !== p_awaddr || o_AWLEN !== p_awlen)) aw_unstable++;
         if (p_ar_st && (!o_ARVALID || o_ARADDR !== p_araddr || o_ARLEN !== p_arlen)) aw_unstable++;
         p_aw_st = o_AWVALID && !i_AWREADY; p_awaddr = o_AWADDR; p_awlen = o_AWLEN;
         p_ar_st = o_ARVALID && !i_ARREADY; p_araddr = o_ARADDR; p_arlen = o_ARLEN;
         if (o_AWVALID && i_AWREADY) begin
            aw_cnt++; aw_addr = o_AWADDR; aw_len = o_AWLEN; aw_size = o_AWSIZE;
            aw_burst = o_AWBURST; aw_id = o_AWID;
         end
         if (o_AWVALID) aw_wait++;
         if (o_ARVALID && i_ARREADY) begin
            ar_cnt++; ar_addr = o_ARADDR; ar_len = o_ARLEN; ar_size = o_ARSIZE;
            ar_burst = o_ARBURST; ar_id = o_ARID; r_act = 1;
         end
         if (o_ARVALID) ar_wait++;
         if (p_w_st && (!o_WVALID || o_WDATA !== p_wdata || o_WLAST !== p_wlast)) stall_bad++;
         p_w_st = o_WVALID && !i_WREADY; p_wdata = o_WDATA; p_wlast = o_WLAST;
         if (o_WVALID && o_WSTRB !== 2'b11) strb_bad++;
         if ((o_WVALID && i_WREADY) != (i_SRC_VALID && o_SRC_READY)) src_mis++;
         if (o_WVALID && i_WREADY) begin
            w_q.push_back(o_WDATA); wl_q.push_back(o_WLAST);
            if (w_q.size() == n) b_pend = 1;
         end
         if (i_SRC_VALID && o_SRC_READY) src_idx++;
         s_hold = i_SRC_VALID && !o_SRC_READY;
         if (o_BREADY && i_BVALID) begin b_cnt++; b_pend = 0; calc_wait = 0; end
         else if (calc_wait >= 0) calc_wait++;
         if (i_RVALID && o_RREADY) rd_idx++;
         rv_hold = i_RVALID && !o_RREADY;
         if (o_RES_VALID && i_RES_READY) res_q.push_back(o_RES_DATA);
         if (c >= 2 && !o_BUSY) break;
      end
      if (c >= max_cyc) timed_out = 1;
      idle_inputs();
   endtask

   task automatic test_reset();
      @(negedge i_clk);
      i_rst = 1; i_START = 1; i_BASE_ADDR = 12'h010; i_NUM_SAMPLES = 9'd4;
      i_SRC_VALID = 1; i_WREADY = 1; i_RVALID = 1; i_RES_READY = 1;
      @(posedge i_clk); #1;
      vectors++;
      if ({o_AWVALID, o_WVALID, o_BREADY, o_ARVALID, o_RES_VALID, o_RREADY, o_SRC_READY} !== 7'd0) begin
         miscompares++; $display("FAIL reset_valids got %b exp 0", {o_AWVALID, o_WVALID, o_BREADY, o_ARVALID, o_RES_VALID, o_RREADY, o_SRC_READY});
      end
      vectors++;
      if ({o_BUSY, o_DONE, o_ERROR} !== 3'd0) begin
         miscompares++; $display("FAIL reset_status got %b exp 000", {o_BUSY, o_DONE, o_ERROR});
      end
      vectors++;
      if (o_AWADDR !== 12'd0 || o_AWLEN !== 8'd0) begin
         miscompares++; $display("FAIL reset_addr_len got %h/%h exp 000/00", o_AWADDR, o_AWLEN);
      end
      @(negedge i_clk);
      idle_inputs(); i_rst = 0;
   endtask

   task automatic test_basic();
      prep_data(4, 1);
      run_job(12'h010, 4, 2, 1, 100, 100, 100, 100, 0, -1, 5, -1, 200);
      vectors++; if (timed_out) begin miscompares++; $display("FAIL basic_timeout got 1 exp 0"); end
      vectors++; if (aw_cnt != 1 || aw_addr !== 12'h010 || aw_len !== 8'd3 || aw_size !== 3'd1 || aw_burst !== 2'd1 || aw_id !== 2'd0) begin
         miscompares++; $display("FAIL basic_aw got n=%0d a=%h l=%h s=%0d b=%0d id=%0d exp 1/010/03/1/1/0", aw_cnt, aw_addr, aw_len, aw_size, aw_burst, aw_id);
      end
      vectors++; if (w_q.size() != 4) begin miscompares++; $display("FAIL basic_wbeats got %0d exp 4", w_q.size()); end
      for (int i = 0; i < w_q.size() && i < 4; i++) begin
         vectors++;
         if (w_q[i] !== 16'((i + 1) * 16'h1111) || wl_q[i] !== (i == 3)) begin
            miscompares++; $display("FAIL basic_w%0d got %h/%b exp %h/%b", i, w_q[i], wl_q[i], 16'((i + 1) * 16'h1111), (i == 3));
         end
      end
      vectors++; if (b_cnt != 1 || ar_early != 0) begin miscompares++; $display("FAIL basic_b_calc got b=%0d early=%0d exp 1/0", b_cnt, ar_early); end
      vectors++; if (ar_cnt != 1 || ar_addr !== 12'h010 || ar_len !== 8'd3 || ar_size !== 3'd2 || ar_burst !== 2'd1 || ar_id !== 2'd0) begin
         miscompares++; $display("FAIL basic_ar got n=%0d a=%h l=%h s=%0d b=%0d id=%0d exp 1/010/03/2/1/0", ar_cnt, ar_addr, ar_len, ar_size, ar_burst, ar_id);
      end
      vectors++; if (res_q.size() != 4) begin miscompares++; $display("FAIL basic_res_cnt got %0d exp 4", res_q.size()); end
      for (int i = 0; i < res_q.size() && i < 4; i++) begin
         vectors++; if (res_q[i] !== rd_q[i]) begin miscompares++; $display("FAIL basic_res%0d got %h exp %h", i, res_q[i], rd_q[i]); end
      end
      vectors++; if (done_cnt != 1 || err_cnt != 0 || aw_unstable != 0) begin
         miscompares++; $display("FAIL basic_end got done=%0d err=%0d unstable=%0d exp 1/0/0", done_cnt, err_cnt, aw_unstable);
      end
   endtask

   task automatic test_backpressure();
      for (int j = 0; j < 6; j++) begin
         int n, base;
         n = $urandom_range(1, 40);
         base = $urandom_range(0, 4096 - 2 * n);
         prep_data(n, 0);
         run_job(base, n, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(60, 90),
                 $urandom_range(60, 90), $urandom_range(60, 90), $urandom_range(60, 90),
                 0, -1, $urandom_range(0, 8), -1, 40 * n + 200);
         vectors++; if (timed_out) begin miscompares++; $display("FAIL bp%0d_timeout got 1 exp 0", j); end
         vectors++; if (w_q.size() != n || res_q.size() != n) begin
            miscompares++; $display("FAIL bp%0d_counts got w=%0d r=%0d exp %0d", j, w_q.size(), res_q.size(), n);
         end
         for (int i = 0; i < w_q.size() && i < n; i++) begin
            vectors++; if (w_q[i] !== src_q[i] || wl_q[i] !== (i == n - 1)) begin
               miscompares++; $display("FAIL bp%0d_w%0d got %h/%b exp %h/%b", j, i, w_q[i], wl_q[i], src_q[i], (i == n - 1));
            end
         end
         for (int i = 0; i < res_q.size() && i < n; i++) begin
            vectors++; if (res_q[i] !== rd_q[i]) begin miscompares++; $display("FAIL bp%0d_r%0d got %h exp %h", j, i, res_q[i], rd_q[i]); end
         end
         vectors++; if (aw_addr !== 12'(base) || aw_len !== 8'(n - 1) || ar_len !== 8'(n - 1)) begin
            miscompares++; $display("FAIL bp%0d_addr got %h/%h/%h exp %h/%h", j, aw_addr, aw_len, ar_len, 12'(base), 8'(n - 1));
         end
         vectors++; if (stall_bad != 0 || strb_bad != 0 || src_mis != 0 || aw_unstable != 0 || ar_early != 0) begin
            miscompares++; $display("FAIL bp%0d_hold got stall=%0d strb=%0d src=%0d unstable=%0d early=%0d exp 0", j, stall_bad, strb_bad, src_mis, aw_unstable, ar_early);
         end
         vectors++; if (done_cnt != 1 || err_cnt != 0) begin miscompares++; $display("FAIL bp%0d_end got done=%0d err=%0d exp 1/0", j, done_cnt, err_cnt); end
      end
   endtask

   task automatic test_max_len();
      int bad_last = 0;
      prep_data(256, 0);
      run_job(0, 256, 0, 0, 85, 85, 85, 85, 0, -1, 2, -1, 3000);
      vectors++; if (timed_out || aw_len !== 8'hFF || w_q.size() != 256) begin
         miscompares++; $display("FAIL max_len got to=%0d len=%h beats=%0d exp 0/ff/256", timed_out, aw_len, w_q.size());
      end
      for (int i = 0; i < wl_q.size(); i++) if (wl_q[i] !== (i == 255)) bad_last++;
      vectors++; if (wl_q.size() != 256 || wl_q[255] !== 1'b1 || bad_last != 0) begin
         miscompares++; $display("FAIL max_wlast got size=%0d misplaced=%0d exp 256/0", wl_q.size(), bad_last);
      end
      vectors++; if (res_q.size() != 256 || done_cnt != 1) begin
         miscompares++; $display("FAIL max_end got res=%0d done=%0d exp 256/1", res_q.size(), done_cnt);
      end
   endtask

   task automatic test_illegal();
      int tb_n[8]    = '{0, 257, 129, 128, 256, 1, 0, 0};
      int tb_base[8] = '{12'h010, 12'h010, 12'hF00, 12'hF00, 12'h000, 12'hFFE, 0, 0};
      for (int j = 0; j < 8; j++) begin
         int n, base;
         bit legal;
         n = (j < 6) ? tb_n[j] : $urandom_range(0, 300);
         base = (j < 6) ? tb_base[j] : $urandom_range(0, 4095);
         legal = model_legal(base, n);
         prep_data(n, 0);
         run_job(base, n, 0, 0, 100, 100, 100, 100, 0, -1, 0, -1, 4 * n + 100);
         vectors++;
         if (legal && (done_cnt != 1 || err_cnt != 0 || aw_cnt != 1 || timed_out)) begin
            miscompares++; $display("FAIL legal_start n=%0d base=%h got done=%0d err=%0d aw=%0d to=%0d exp 1/0/1/0", n, base, done_cnt, err_cnt, aw_cnt, timed_out);
         end else if (!legal && (err_cnt != 1 || aw_first >= 0 || done_cnt != 0 || timed_out)) begin
            miscompares++; $display("FAIL illegal_start n=%0d base=%h got err=%0d awvalid_seen=%0d done=%0d exp 1/0/0", n, base, err_cnt, (aw_first >= 0), done_cnt);
         end
      end
   endtask

   task automatic test_protocol_errors();
      prep_data(4, 0);
      run_job(12'h100, 4, 0, 0, 100, 100, 100, 100, 0, 1, 0, -1, 200);
      vectors++; if (err_cnt != 1 || done_cnt != 0 || timed_out) begin
         miscompares++; $display("FAIL early_rlast got err=%0d done=%0d to=%0d exp 1/0/0", err_cnt, done_cnt, timed_out);
      end
      prep_data(4, 0);
      run_job(12'h100, 4, 0, 0, 100, 100, 100, 100, 0, 99, 0, -1, 200);
      vectors++; if (err_cnt != 1 || done_cnt != 0 || timed_out) begin
         miscompares++; $display("FAIL missing_rlast got err=%0d done=%0d to=%0d exp 1/0/0", err_cnt, done_cnt, timed_out);
      end
      prep_data(4, 0);
      run_job(12'h100, 4, 0, 0, 100, 100, 100, 100, 1, -1, 0, -1, 200);
      vectors++; if (err_cnt != 1 || done_cnt != 0 || ar_cnt != 0 || timed_out) begin
         miscompares++; $display("FAIL bad_bid got err=%0d done=%0d ar=%0d to=%0d exp 1/0/0/0", err_cnt, done_cnt, ar_cnt, timed_out);
      end
   endtask

   task automatic test_reset_mid_burst();
      prep_data(8, 0);
      run_job(12'h040, 8, 0, 0, 100, 100, 100, 100, 0, -1, 0, 2, 200);
      vectors++; if (post_rst_bad !== 1'b0 || w_q.size() != 2) begin
         miscompares++; $display("FAIL mid_reset got active=%b beats=%0d exp 0/2", post_rst_bad, w_q.size());
      end
      prep_data(5, 0);
      run_job(12'h080, 5, 1, 1, 100, 100, 100, 100, 0, -1, 1, -1, 200);
      vectors++; if (done_cnt != 1 || err_cnt != 0 || w_q.size() != 5 || res_q.size() != 5 || timed_out) begin
         miscompares++; $display("FAIL after_reset got done=%0d err=%0d w=%0d r=%0d exp 1/0/5/5", done_cnt, err_cnt, w_q.size(), res_q.size());
      end
      for (int i = 0; i < w_q.size() && i < 5; i++) begin
         vectors++; if (w_q[i] !== src_q[i]) begin miscompares++; $display("FAIL after_reset_w%0d got %h exp %h", i, w_q[i], src_q[i]); end
      end
   endtask

`ifdef AXI_FFT_MASTER_TIMEOUT_EN
   task automatic test_timeout();
      prep_data(4, 0);
      run_job(12'h020, 4, 100000, 0, 100, 100, 100, 100, 0, -1, 0, -1, 200);
      vectors++; if (err_cnt != 1 || (err_first - aw_first) != 16 || aw_at_err !== 1'b0 || aw_cnt != 0 || timed_out) begin
         miscompares++; $display("FAIL timeout got err=%0d delay=%0d awvalid=%b aw=%0d exp 1/16/0/0", err_cnt, err_first - aw_first, aw_at_err, aw_cnt);
      end
   endtask
`endif

   initial begin
      idle_inputs();
      i_rst = 1; i_BASE_ADDR = 0; i_NUM_SAMPLES = 0;
      apply_reset();
      test_reset();
      test_basic();
      test_backpressure();
      test_max_len();
      test_illegal();
      test_protocol_errors();
      test_reset_mid_burst();
`ifdef AXI_FFT_MASTER_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/axi_fft_master.md
Name: axi_fft_master

Overview:
- AXI4 initiator that drives the FFT sample-RAM bridge from the system side.
- On a start command it issues one INCR write burst of 16-bit samples taken from a local source stream, then collects the write response.
- It then waits for FFT calculation end, issues one INCR read burst of 32-bit results, and forwards them to a local sink stream.
- Sits between the host/DMA sample source and the bridge's AXI slave ports.

Parameters:
DATA_WIDTH, 32, read data / result width
ID_W_WIDTH, 2, AWID/BID width
ID_R_WIDTH, 2, ARID/RID width
WR_ID, 0, constant AWID used for every write burst
RD_ID, 0, constant ARID used for every read burst
TIMEOUT_CYCLES, 1024, watchdog limit (only with the optional feature)

Ports:
i_clk in 1 clock, all logic on rising edge
i_rst in 1 synchronous active-high reset
i_START in 1 start one write/calc/read job (sampled in IDLE only)
i_BASE_ADDR in 12 byte base address for both bursts
i_NUM_SAMPLES in 9 burst length N, legal 1..256
i_CALC_END in 1 FFT core finished, level
i_SRC_DATA in 16 / i_SRC_VALID in 1 / o_SRC_READY out 1 sample source stream
o_RES_DATA out DATA_WIDTH / o_RES_VALID out 1 / i_RES_READY in 1 result sink stream
o_BUSY out 1 job in progress; o_DONE out 1 one-cycle pulse at job end; o_ERROR out 1 one-cycle error pulse
o_AWADDR 12, o_AWLEN 8, o_AWSIZE 3, o_AWBURST 2, o_AWID ID_W_WIDTH, o_AWVALID 1 out; i_AWREADY in 1
o_WDATA 16, o_WSTRB 2, o_WVALID 1, o_WLAST 1 out; i_WREADY in 1
i_BVALID 1, i_BID ID_W_WIDTH in; o_BREADY out 1
o_ARADDR 12, o_ARLEN 8, o_ARSIZE 3, o_ARBURST 2, o_ARID ID_R_WIDTH, o_ARVALID 1 out; i_ARREADY in 1
i_RDATA DATA_WIDTH, i_RID ID_R_WIDTH, i_RVALID 1, i_RLAST 1 in; o_RREADY out 1

Behaviour:
- Reset (i_rst high at edge): state IDLE; beat counter 0; all VALID/READY, o_BUSY, o_DONE and o_ERROR are 0; address/len registers 0. Reset mid-burst abandons the job with no further beats; the next edge after deassert is IDLE.
- States: IDLE, AW, W, B, WAIT_CALC, AR, R, DONE.
- IDLE: start is legal when i_START, 1<=N<=256, and i_BASE_ADDR + 2N <= 4096.
  - Legal start: latch base and N, then go to AW.
  - Illegal start: pulse o_ERROR and stay IDLE.
- AW: o_AWVALID=1, AWADDR=base, AWLEN=N-1, AWSIZE=3'b001, AWBURST=2'b01, AWID=WR_ID. All fields are stable until i_AWREADY. On handshake go to W with counter 0.
- W: o_WVALID=i_SRC_VALID, o_WDATA=i_SRC_DATA, o_WSTRB=2'b11, o_SRC_READY=i_WREADY (combinational pass-through, zero latency).
  - o_WLAST=1 when counter==N-1.
  - Each WVALID&WREADY beat increments the counter.
  - The last beat goes to B.
- B: o_BREADY=1. On i_BVALID go to WAIT_CALC; i_BID != WR_ID pulses o_ERROR and goes to IDLE.
- WAIT_CALC: hold until i_CALC_END=1, then go to AR.
- AR: same rules as AW with ARSIZE=3'b010, ARID=RD_ID, ARLEN=N-1. On handshake go to R with counter 0.
- R: o_RES_DATA=i_RDATA, o_RES_VALID=i_RVALID, o_RREADY=i_RES_READY. Each RVALID&RREADY beat increments the counter.
  - Last beat (counter==N-1) must carry RLAST=1; then go to DONE.
  - RLAST on an earlier beat, missing RLAST on the last beat, or RID != RD_ID: pulse o_ERROR, go to IDLE.
- DONE: o_DONE=1 for one cycle, then IDLE.
- o_BUSY=1 in every state except IDLE.
- i_START outside IDLE is ignored; the start request is not queued.
- Counter is 9 bits; N=256 gives AWLEN=8'hFF. Address arithmetic is 13-bit to detect the 4 KB overflow.

Optional Feature:
- Macro AXI_FFT_MASTER_TIMEOUT_EN.
- When defined: a watchdog counts consecutive cycles spent in AW, W, B, AR or R without a handshake. Reaching TIMEOUT_CYCLES pulses o_ERROR, drops all VALID/READY, and returns to IDLE. The watchdog does not run in WAIT_CALC.
- When undefined: no watchdog; a stalled slave stalls the block indefinitely.

Decomposition:
- Shared package holds: state enum typedef (master_fsm), AXI burst/size constants (BURST_INCR=2'b01, SIZE_2B=3'b001, SIZE_4B=3'b010), and MAX_BURST=256.
- One natural sub-module, axi_fft_master_beat_cnt: the beat counter with clear, enable, and last-beat compare, shared by W and R phases.

Test Plan:
- N=4, base 0x010, source streams 0x1111..0x4444, AWREADY after 2 cycles: AWLEN=3, AWSIZE=1, 4 W beats with WLAST on 0x4444, BREADY taken, then waits for CALC_END; the AR burst returns 4 words to the sink and o_DONE pulses once.
- Backpressure: SRC_VALID toggles, WREADY low 3 cycles mid-burst, RES_READY low on beat 2 -> no beats lost or duplicated; WDATA/WLAST held while stalled.
- N=256, base 0x000 -> AWLEN=0xFF, last beat carries WLAST. N=0, N=257, or base 0xF00 with N=129 -> o_ERROR pulse, no AWVALID.
- RLAST asserted on beat 1 of 4, or BID=1 -> o_ERROR pulse, return to IDLE, o_DONE never asserted.
- i_rst asserted during W beat 2 -> next cycle all VALIDs 0 and state IDLE; a new start then completes normally.
- With AXI_FFT_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, AWREADY held low -> o_ERROR exactly 16 cycles after AW entry, AWVALID drops.
